imm_decode_stage: RTL and testbench

- Pipelined successor to the combinational immediate generator.
- Sits between fetch and decode/execute: accepts one 32-bit instruction and its PC per valid/ready handshake.
- Derives the format from the opcode itself; no external type select.
- Produces an XLEN-wide sign-extended immediate, format code, illegal flag and precomputed control-flow target.
- Holds results in a 2-entry skid buffer, so backpressure from downstream never drops instructions.

---
 rtl/imm_pkg.sv | 40 ++++
 rtl/imm_decode_stage_if.sv | 33 +++
 rtl/imm_decode_stage_extract.sv | 85 ++++++++
 rtl/imm_decode_stage.sv | 110 +++++++++++
 tb/tb_imm_decode_stage.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the immediate decode stage.
// sext() widens a 32-bit field to 64 bits; callers truncate to XLEN.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_I   = 3'd0,
    FMT_U   = 3'd1,
    FMT_S   = 3'd2,
    FMT_R   = 3'd3,
    FMT_B   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  function automatic logic [63:0] sext(
    input logic [31:0] value,
    input int unsigned from_bit
  );
    logic signed [63:0] t;
    int unsigned        sh;
    sh = 63 - from_bit;
    t  = signed'({32'b0, value} << sh);
    return t >>> sh;
  endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// Upstream/downstream handshake bundle of the immediate decode stage.
// master = environment side, slave = the stage itself.
interface imm_decode_stage_if #(
  parameter int XLEN = 32
);
  import imm_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  fmt_e            out_fmt;
  logic            out_illegal;
  logic [XLEN-1:0] out_target;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc,
    input  out_imm, out_fmt, out_illegal, out_target
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc,
    output out_imm, out_fmt, out_illegal, out_target
  );

endinterface

// File: rtl/imm_decode_stage_extract.sv
// Combinational opcode-driven format decode and immediate extraction.
// Output is XLEN wide; RV64 adds OP-IMM-32, OP-32 and 6-bit shamts.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output fmt_e            fmt_o,
  output logic            illegal_o
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0] opc;
  logic [2:0] f3;
  logic is_w, is_i, is_u, is_s;
  logic is_r, is_b, is_j, is_shift;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];

  always_comb begin
    is_w = RV64 && (opc == OPC_OP_IMM_32);
    is_i = (opc == OPC_LOAD) || (opc == OPC_OP_IMM)
        || (opc == OPC_JALR) || (opc == OPC_SYSTEM)
        || (opc == OPC_MISC_MEM) || is_w;
    is_u = (opc == OPC_LUI) || (opc == OPC_AUIPC);
    is_s = (opc == OPC_STORE);
    is_r = (opc == OPC_OP)
        || (RV64 && (opc == OPC_OP_32));
    is_b = (opc == OPC_BRANCH);
    is_j = (opc == OPC_JAL);
    is_shift = ((opc == OPC_OP_IMM) || is_w)
            && ((f3 == 3'b001) || (f3 == 3'b101));
  end

  always_comb begin
    fmt_o     = FMT_ILL;
    imm_o     = '0;
    illegal_o = 1'b0;
    unique case (1'b1)
      is_i: begin
        fmt_o = FMT_I;
        // shifts carry a zero-extended shamt, not a signed imm
        if (is_shift && (!RV64 || is_w))
          imm_o = XLEN'(instr_i[24:20]);
        else if (is_shift)
          imm_o = XLEN'(instr_i[25:20]);
        else
          imm_o = XLEN'(sext({20'b0, instr_i[31:20]}, 11));
      end
      is_u: begin
        fmt_o = FMT_U;
        imm_o = XLEN'(sext({instr_i[31:12], 12'b0}, 31));
      end
      is_s: begin
        fmt_o = FMT_S;
        imm_o = XLEN'(sext({20'b0, instr_i[31:25],
                            instr_i[11:7]}, 11));
      end
      is_r: begin
        fmt_o = FMT_R;
      end
      is_b: begin
        fmt_o = FMT_B;
        imm_o = XLEN'(sext({19'b0, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8],
                            1'b0}, 12));
      end
      is_j: begin
        fmt_o = FMT_J;
        imm_o = XLEN'(sext({11'b0, instr_i[31],
                            instr_i[19:12], instr_i[20],
                            instr_i[30:21], 1'b0}, 20));
      end
      default: begin
        fmt_o     = FMT_ILL;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode stage: extract, precompute target, 2-entry skid FIFO.
// Head entry drives every output; flush empties the buffer.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  imm_decode_stage_if.slave bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_decode_stage: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] tgt;
    fmt_e            fmt;
    logic            ill;
  } ent_t;

  ent_t [1:0] mem_q, mem_d;
  logic       head_q, head_d;
  logic       tail_q, tail_d;
  logic [1:0] cnt_q, cnt_d;

  logic [XLEN-1:0] x_imm;
  fmt_e            x_fmt;
  logic            x_ill;
  logic            is_cf;
  logic [XLEN-1:0] new_tgt;
  ent_t            new_ent;
  ent_t            head;
  logic            push, pop;

  imm_extract #(
    .XLEN (XLEN)
  ) u_extract (
    .instr_i   (bus.in_instr),
    .imm_o     (x_imm),
    .fmt_o     (x_fmt),
    .illegal_o (x_ill)
  );

  // target is stored so no adder sits on the output path
  assign is_cf   = (x_fmt == FMT_B) || (x_fmt == FMT_J);
  assign new_tgt = bus.in_pc + (is_cf ? x_imm : XLEN'(4));

  assign new_ent = '{
    instr: bus.in_instr,
    pc:    bus.in_pc,
    imm:   x_imm,
    tgt:   new_tgt,
    fmt:   x_fmt,
    ill:   x_ill
  };

  assign bus.in_ready  = (cnt_q != 2'd2);
  assign bus.out_valid = (cnt_q != 2'd0);

  assign push = bus.in_valid && bus.in_ready && !flush;
  assign pop  = bus.out_valid && bus.out_ready;

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush) begin
      head_d = 1'b0;
      tail_d = 1'b0;
      cnt_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[tail_q] = new_ent;
        tail_d        = ~tail_q;
      end
      if (pop) head_d = ~head_q;
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      head_q <= 1'b0;
      tail_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head            = mem_q[head_q];
  assign bus.out_instr   = head.instr;
  assign bus.out_pc      = head.pc;
  assign bus.out_imm     = head.imm;
  assign bus.out_fmt     = head.fmt;
  assign bus.out_illegal = head.ill;
  assign bus.out_target  = head.tgt;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: XLEN=32 and XLEN=64 instances,
// vector table through a scoreboard plus buffer corner sequences.
module tb_imm_decode_stage;
  import imm_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  always #5 clk = ~clk;

  imm_decode_stage_if #(.XLEN(32)) b32();
  imm_decode_stage_if #(.XLEN(64)) b64();

  imm_decode_stage #(.XLEN(32)) u32 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (b32)
  );

  imm_decode_stage #(.XLEN(64)) u64 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (b64)
  );

  typedef struct {
    bit          rv64;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [63:0] tgt;
  } vec_t;

  vec_t tab[$];
  vec_t q32[$];
  vec_t q64[$];

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit rv64,
                              input logic [31:0] ins,
                              input logic [63:0] pc,
                              input logic [63:0] imm,
                              input logic [2:0] fmt,
                              input logic ill,
                              input logic [63:0] tgt);
    vec_t v;
    v.rv64 = rv64; v.instr = ins; v.pc = pc;
    v.imm = imm; v.fmt = fmt; v.ill = ill; v.tgt = tgt;
    return v;
  endfunction

  // scoreboard: compare head against oldest expectation on each pop
  always @(negedge clk) begin
    if (rst_n && b32.out_valid && b32.out_ready) begin
      if (q32.size() == 0) begin
        n_run++; n_fail++;
        $display("FAIL o32.unexpected: got instr %h, expected none",
                 b32.out_instr);
      end else begin
        vec_t e;
        e = q32.pop_front();
        chk("o32.instr", 64'(b32.out_instr), 64'(e.instr));
        chk("o32.pc", 64'(b32.out_pc), e.pc);
        chk("o32.imm", 64'(b32.out_imm), e.imm);
        chk("o32.fmt", 64'(b32.out_fmt), 64'(e.fmt));
        chk("o32.ill", 64'(b32.out_illegal), 64'(e.ill));
        chk("o32.tgt", 64'(b32.out_target), e.tgt);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b64.out_valid && b64.out_ready) begin
      if (q64.size() == 0) begin
        n_run++; n_fail++;
        $display("FAIL o64.unexpected: got instr %h, expected none",
                 b64.out_instr);
      end else begin
        vec_t e;
        e = q64.pop_front();
        chk("o64.instr", 64'(b64.out_instr), 64'(e.instr));
        chk("o64.pc", b64.out_pc, e.pc);
        chk("o64.imm", b64.out_imm, e.imm);
        chk("o64.fmt", 64'(b64.out_fmt), 64'(e.fmt));
        chk("o64.ill", 64'(b64.out_illegal), 64'(e.ill));
        chk("o64.tgt", b64.out_target, e.tgt);
      end
    end
  end

  // called at posedge+1; returns at posedge+1 after acceptance
  task automatic send(input vec_t v);
    int k;
    if (v.rv64) begin
      b64.in_valid = 1'b1;
      b64.in_instr = v.instr;
      b64.in_pc    = v.pc;
    end else begin
      b32.in_valid = 1'b1;
      b32.in_instr = v.instr;
      b32.in_pc    = v.pc[31:0];
    end
    for (k = 0; k < 20; k++) begin
      if (v.rv64 ? b64.in_ready : b32.in_ready) break;
      @(posedge clk); #1;
    end
    if (k == 20) begin
      n_run++; n_fail++;
      $display("FAIL send.timeout: got in_ready=0, expected 1");
    end else begin
      if (v.rv64) q64.push_back(v);
      else q32.push_back(v);
      @(posedge clk); #1;
    end
    b32.in_valid = 1'b0;
    b64.in_valid = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    b32.in_valid = 1'b0; b32.in_instr = '0;
    b32.in_pc = '0; b32.out_ready = 1'b1;
    b64.in_valid = 1'b0; b64.in_instr = '0;
    b64.in_pc = '0; b64.out_ready = 1'b1;

    tab.push_back(mk(0, 32'hFFF00093, 64'h100,
      64'hFFFFFFFF, 3'd0, 0, 64'h104));
    tab.push_back(mk(0, 32'hFE000CE3, 64'h200,
      64'hFFFFFFF8, 3'd4, 0, 64'h1F8));
    tab.push_back(mk(0, 32'h0010006F, 64'h300,
      64'h800, 3'd5, 0, 64'hB00));
    tab.push_back(mk(0, 32'h800002B7, 64'h400,
      64'h80000000, 3'd1, 0, 64'h404));
    tab.push_back(mk(0, 32'hFE20AE23, 64'h500,
      64'hFFFFFFFC, 3'd2, 0, 64'h504));
    tab.push_back(mk(0, 32'h002081B3, 64'h600,
      64'h0, 3'd3, 0, 64'h604));
    tab.push_back(mk(0, 32'h0000001B, 64'h700,
      64'h0, 3'd7, 1, 64'h704));
    tab.push_back(mk(0, 32'h00000010, 64'h800,
      64'h0, 3'd7, 1, 64'h804));
    tab.push_back(mk(0, 32'h01F09093, 64'h900,
      64'h1F, 3'd0, 0, 64'h904));
    tab.push_back(mk(0, 32'h4030D093, 64'hA00,
      64'h3, 3'd0, 0, 64'hA04));
    tab.push_back(mk(0, 32'hFE000CE3, 64'h4,
      64'hFFFFFFF8, 3'd4, 0, 64'hFFFFFFFC));
    tab.push_back(mk(0, 32'h12345097, 64'hB00,
      64'h12345000, 3'd1, 0, 64'hB04));
    tab.push_back(mk(0, 32'h7FF02083, 64'hC00,
      64'h7FF, 3'd0, 0, 64'hC04));
    tab.push_back(mk(0, 32'h002081BB, 64'hD00,
      64'h0, 3'd7, 1, 64'hD04));
    tab.push_back(mk(1, 32'h800002B7, 64'h1000,
      64'hFFFFFFFF80000000, 3'd1, 0, 64'h1004));
    tab.push_back(mk(1, 32'h02809093, 64'h1100,
      64'd40, 3'd0, 0, 64'h1104));
    tab.push_back(mk(1, 32'h0210909B, 64'h1200,
      64'h1, 3'd0, 0, 64'h1204));
    tab.push_back(mk(1, 32'hFFF0009B, 64'h1300,
      64'hFFFFFFFFFFFFFFFF, 3'd0, 0, 64'h1304));
    tab.push_back(mk(1, 32'h002081BB, 64'h1400,
      64'h0, 3'd3, 0, 64'h1404));
    tab.push_back(mk(1, 32'hFFDFF06F, 64'h2000,
      64'hFFFFFFFFFFFFFFFC, 3'd5, 0, 64'h1FFC));
    tab.push_back(mk(1, 32'h43F0D093, 64'h1500,
      64'h3F, 3'd0, 0, 64'h1504));
    tab.push_back(mk(1, 32'hFFF00093, 64'hFFFFFFFFFFFFFFFC,
      64'hFFFFFFFFFFFFFFFF, 3'd0, 0, 64'h0));
    tab.push_back(mk(1, 32'hFE000CE3, 64'h100000000,
      64'hFFFFFFFFFFFFFFF8, 3'd4, 0, 64'hFFFFFFF8));

    #7;
    chk("rst.valid", 64'(b32.out_valid), 64'd0);
    chk("rst.ready", 64'(b32.in_ready), 64'd1);
    chk("rst.imm", 64'(b32.out_imm), 64'd0);
    chk("rst.tgt", b64.out_target, 64'd0);
    #6 rst_n = 1'b1;
    @(posedge clk); #1;

    // first push: visible the very next cycle
    send(tab[0]);
    chk("lat.valid", 64'(b32.out_valid), 64'd1);
    chk("lat.fmt", 64'(b32.out_fmt), 64'd0);
    chk("lat.imm", 64'(b32.out_imm), 64'hFFFFFFFF);
    chk("lat.tgt", 64'(b32.out_target), 64'h104);
    for (int i = 1; i < tab.size(); i++) send(tab[i]);
    cyc(4);

    // count=1 with push and pop together
    send(tab[1]);
    send(tab[2]);
    chk("pp.valid", 64'(b32.out_valid), 64'd1);
    chk("pp.head", 64'(b32.out_instr), 64'(tab[2].instr));
    chk("pp.ready", 64'(b32.in_ready), 64'd1);
    cyc(3);

    // backpressure: two accepted, third stalls until a pop
    b32.out_ready = 1'b0;
    send(tab[3]);
    send(tab[4]);
    chk("bp.ready", 64'(b32.in_ready), 64'd0);
    chk("bp.head", 64'(b32.out_instr), 64'(tab[3].instr));
    b32.in_valid = 1'b1;
    b32.in_instr = tab[5].instr;
    cyc(1);
    b32.in_valid = 1'b0;
    chk("bp.stable", 64'(b32.out_imm), tab[3].imm);
    chk("bp.ready2", 64'(b32.in_ready), 64'd0);
    b32.out_ready = 1'b1;
    send(tab[5]);
    cyc(4);

    // flush with a full buffer and a same-cycle input
    b32.out_ready = 1'b0;
    send(tab[6]);
    send(tab[7]);
    flush = 1'b1;
    b32.in_valid = 1'b1;
    b32.in_instr = tab[8].instr;
    b32.in_pc = tab[8].pc[31:0];
    cyc(1);
    flush = 1'b0;
    b32.in_valid = 1'b0;
    q32.delete();
    chk("fl2.valid", 64'(b32.out_valid), 64'd0);
    chk("fl2.ready", 64'(b32.in_ready), 64'd1);
    b32.out_ready = 1'b1;
    cyc(3);
    chk("fl2.empty", 64'(b32.out_valid), 64'd0);

    // flush racing a legal push at count=1
    b32.out_ready = 1'b0;
    send(tab[9]);
    flush = 1'b1;
    b32.in_valid = 1'b1;
    b32.in_instr = tab[10].instr;
    cyc(1);
    flush = 1'b0;
    b32.in_valid = 1'b0;
    q32.delete();
    chk("fl1.valid", 64'(b32.out_valid), 64'd0);
    b32.out_ready = 1'b1;
    cyc(3);
    chk("fl1.empty", 64'(b32.out_valid), 64'd0);
    send(tab[11]);
    cyc(3);

    // asynchronous reset with two entries held
    b64.out_ready = 1'b0;
    send(tab[14]);
    send(tab[15]);
    chk("ar.pre", 64'(b64.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    q64.delete();
    chk("ar.valid", 64'(b64.out_valid), 64'd0);
    chk("ar.ready", 64'(b64.in_ready), 64'd1);
    chk("ar.imm", b64.out_imm, 64'd0);
    chk("ar.instr", 64'(b64.out_instr), 64'd0);
    cyc(1);
    #3 rst_n = 1'b1;
    cyc(1);
    b64.out_ready = 1'b1;
    chk("ar.rel.ready", 64'(b64.in_ready), 64'd1);
    chk("ar.rel.valid", 64'(b64.out_valid), 64'd0);
    chk("ar.rel.pc", b64.out_pc, 64'd0);
    chk("ar.rel.tgt", b64.out_target, 64'd0);
    chk("ar.rel.imm32", 64'(b32.out_imm), 64'd0);
    send(tab[16]);
    cyc(4);

    chk("sb.q32", 64'(q32.size()), 64'd0);
    chk("sb.q64", 64'(q64.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
